stdp_pulse_gen: RTL and testbench
=================================

Name: stdp_pulse_gen

Overview:
- Upstream learning controller for the unary feedback shift-register weight store.
- Observes input-spike and output-spike timing within each gamma window and applies a simplified STDP rule.
- Emits single-cycle inc/dec pulses that drive the weight store's inc/dec pins directly.
- Reads the store's thermometer-coded weight back to suppress updates at saturation.

Parameters:
INPUT_SIZE, 8, width of the thermometer weight; maximum weight value.
CNT_W, 5, width of the in-window time counter; the counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
gamma  input  1  single-cycle pulse marking the start of a new gamma window.
learn_en  input  1  1 = updates permitted; 0 = observe only, inc/dec held low.
in_spike  input  1  presynaptic spike pulse.
out_spike  input  1  postsynaptic spike pulse.
weight  input  [0:INPUT_SIZE-1]  current thermometer weight; value k means bits 0..k-1 are 1.
inc  output  1  single-cycle increment request to the weight store.
dec  output  1  single-cycle decrement request to the weight store.
win_valid  output  1  high while at least one gamma has been seen since reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - inc=0, dec=0, win_valid=0.
  - Time counter t=0; flags seen_in=0, seen_out=0; t_in=0, t_out=0.
  - State = IDLE.
- States: IDLE, OBSERVE.
  - IDLE -> OBSERVE on the first gamma; win_valid goes 1 on the following edge.
  - There is no return to IDLE except via reset.
- Time counter in OBSERVE:
  - t=0 on a gamma cycle; otherwise t+1, saturating at 2^CNT_W-1 (no wrap).
- Spike capture:
  - The first in_spike of a window latches t_in=t and sets seen_in. The same applies to out_spike -> t_out, seen_out.
  - Later spikes in the same window are ignored.
  - A spike arriving in the same cycle as gamma belongs to the NEW window at t=0. The old window's flags are evaluated first, then cleared and re-set by that spike.
- Decision at each gamma while in OBSERVE:
  - Uses the closing window's flags and times.
  - seen_in & seen_out & t_in<=t_out -> capture: inc.
  - seen_in & seen_out & t_in>t_out -> backoff: dec.
  - seen_in & !seen_out -> search: inc.
  - !seen_in & seen_out -> backoff: dec.
  - neither -> no update.
- Saturation:
  - inc is suppressed if weight[INPUT_SIZE-1]=1 (full).
  - dec is suppressed if weight[0]=0 (zero).
  - weight is sampled in the gamma cycle.
- Output timing:
  - inc/dec are registered and asserted in the cycle immediately after the gamma edge, for exactly one cycle.
  - inc and dec are never high together.
  - learn_en is sampled in the gamma cycle; learn_en=0 forces no pulse.
- First gamma from IDLE: no decision and no pulse; the previous window is undefined.
- Back-to-back gamma (consecutive cycles): each gamma produces a decision for its one-cycle window; pulses can occur on consecutive cycles.
- Reset mid-window:
  - All captured state is discarded.
  - A pending inc/dec is cleared immediately.
  - Learning resumes only after two gammas (IDLE -> OBSERVE, then first decision).

Test Plan:
- Reset; gamma at cycle 2; gamma at cycle 20 with no spikes -> win_valid=1 from cycle 3; inc=dec=0 throughout.
- weight=8'b1110_0000:
  - Window 1: in_spike at t=3, out_spike at t=7; next gamma -> inc=1 for exactly 1 cycle, 1 cycle after gamma; dec=0.
  - Next window: in_spike at t=9, out_spike at t=4 -> dec pulse.
- Window with in_spike only (t=5), weight=8'b1111_1111 -> no inc (full suppression).
  - Repeat with weight=8'b1111_1110 -> inc pulse.
- Window with out_spike only, weight=8'b0000_0000 -> no dec.
  - Repeat with weight=8'b1000_0000 -> dec pulse.
- Edge cases:
  - in_spike coincident with gamma -> counted at t=0 of the new window, no effect on the old decision.
  - Second in_spike at t=10 after the first at t=2 with out_spike at t=6 -> inc (first spike wins).
  - learn_en=0 at gamma -> no pulse.
- Assert rst=0 in the cycle after gamma while inc is high -> inc drops asynchronously.
  - After release, the first gamma gives no pulse; the second gamma decides normally.

Source files
------------

// File: rtl/stdp_pulse_gen.sv
// STDP learning controller: watches pre/post spike timing per gamma window and
// issues one-cycle inc/dec pulses to a unary weight store, respecting saturation.
//
// state    | meaning
// S_IDLE   | no gamma seen since reset; window timing undefined
// S_OBSERVE| inside a gamma window; counting time and capturing first spikes
module stdp_pulse_gen #(
  parameter int INPUT_SIZE = 8,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gamma,
  input  logic                  learn_en,
  input  logic                  in_spike,
  input  logic                  out_spike,
  input  logic [0:INPUT_SIZE-1] weight,
  output logic                  inc,
  output logic                  dec,
  output logic                  win_valid
);

  typedef enum logic {S_IDLE, S_OBSERVE} state_t;

  localparam logic [CNT_W-1:0] T_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_decide;
  logic [CNT_W-1:0] r_t;
  logic [CNT_W-1:0] r_t_in;
  logic [CNT_W-1:0] r_t_out;
  logic             r_seen_in;
  logic             r_seen_out;
  logic             r_inc;
  logic             r_dec;
  logic             w_inc_rule;
  logic             w_dec_rule;
  logic             w_unused_weight;

  // Only the end bits of the thermometer code matter for saturation.
  assign w_unused_weight = ^weight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_decide    = 1'b0;
    case (r_state)
      S_IDLE:    if (gamma) w_state_nxt = S_OBSERVE;
      S_OBSERVE: w_decide = gamma;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // A spike coincident with gamma opens the new window at t=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t        <= '0;
      r_t_in     <= '0;
      r_t_out    <= '0;
      r_seen_in  <= 1'b0;
      r_seen_out <= 1'b0;
    end else if (gamma) begin
      r_t        <= '0;
      r_t_in     <= '0;
      r_t_out    <= '0;
      r_seen_in  <= in_spike;
      r_seen_out <= out_spike;
    end else if (r_state == S_OBSERVE) begin
      if (r_t != T_MAX) r_t <= r_t + 1'b1;
      if (in_spike && !r_seen_in) begin
        r_seen_in <= 1'b1;
        r_t_in    <= r_t;
      end
      if (out_spike && !r_seen_out) begin
        r_seen_out <= 1'b1;
        r_t_out    <= r_t;
      end
    end
  end

  assign w_inc_rule = r_seen_in  && (!r_seen_out || (r_t_in <= r_t_out));
  assign w_dec_rule = r_seen_out && (!r_seen_in  || (r_t_in >  r_t_out));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_inc <= w_decide && learn_en && w_inc_rule && !weight[INPUT_SIZE-1];
      r_dec <= w_decide && learn_en && w_dec_rule && weight[0];
    end
  end

  assign inc       = r_inc;
  assign dec       = r_dec;
  assign win_valid = (r_state == S_OBSERVE);

endmodule

// File: tb/tb_stdp_pulse_gen.sv
// Directed bench for stdp_pulse_gen: each window() call opens a new gamma window
// and returns the pulse produced by the decision on the window it closed.
module tb_stdp_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       gamma;
  logic       learn_en;
  logic       in_spike;
  logic       out_spike;
  logic [0:7] weight;
  logic       inc;
  logic       dec;
  logic       win_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic p_inc;
  logic p_dec;

  stdp_pulse_gen #(.INPUT_SIZE(8), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .gamma     (gamma),
    .learn_en  (learn_en),
    .in_spike  (in_spike),
    .out_spike (out_spike),
    .weight    (weight),
    .inc       (inc),
    .dec       (dec),
    .win_valid (win_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input logic g, input logic i, input logic o);
    gamma     = g;
    in_spike  = i;
    out_spike = o;
    @(posedge clk);
    #1;
    gamma     = 1'b0;
    in_spike  = 1'b0;
    out_spike = 1'b0;
  endtask

  // Gamma at t=0, then len-1 more cycles; spikes at the given window times (-1 = none).
  task automatic window(input int len, input int ti, input int to, input int ti2,
                        output logic o_inc, output logic o_dec);
    for (int t = 0; t < len; t++) begin
      do_cycle(t == 0, (t == ti) || (t == ti2), t == to);
      if (t == 0) begin
        o_inc = inc;
        o_dec = dec;
      end else begin
        chk("quiet_inc", inc, 1'b0);
        chk("quiet_dec", dec, 1'b0);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    gamma     = 1'b0;
    learn_en  = 1'b1;
    in_spike  = 1'b0;
    out_spike = 1'b0;
    weight    = 8'b0000_0000;
    #3;
    chk("rst_inc", inc, 1'b0);
    chk("rst_dec", dec, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    chk("idle_win_valid", win_valid, 1'b0);

    // First gamma from IDLE: no decision
    window(18, -1, -1, -1, p_inc, p_dec);
    chk("first_gamma_inc", p_inc, 1'b0);
    chk("first_gamma_dec", p_dec, 1'b0);
    chk("win_valid_set", win_valid, 1'b1);

    weight = 8'b1110_0000;
    window(12, 3, 7, -1, p_inc, p_dec);
    chk("empty_win_inc", p_inc, 1'b0);
    chk("empty_win_dec", p_dec, 1'b0);

    window(12, 9, 4, -1, p_inc, p_dec);
    chk("capture_inc", p_inc, 1'b1);
    chk("capture_dec", p_dec, 1'b0);

    window(8, 5, -1, -1, p_inc, p_dec);
    chk("backoff_inc", p_inc, 1'b0);
    chk("backoff_dec", p_dec, 1'b1);

    weight = 8'b1111_1111;
    window(8, 5, -1, -1, p_inc, p_dec);
    chk("full_supp_inc", p_inc, 1'b0);
    chk("full_supp_dec", p_dec, 1'b0);

    weight = 8'b1111_1110;
    window(8, -1, 3, -1, p_inc, p_dec);
    chk("search_inc", p_inc, 1'b1);
    chk("search_dec", p_dec, 1'b0);

    weight = 8'b0000_0000;
    window(8, -1, 3, -1, p_inc, p_dec);
    chk("zero_supp_inc", p_inc, 1'b0);
    chk("zero_supp_dec", p_dec, 1'b0);

    weight = 8'b1000_0000;
    window(8, -1, -1, -1, p_inc, p_dec);
    chk("out_only_inc", p_inc, 1'b0);
    chk("out_only_dec", p_dec, 1'b1);

    // in_spike coincident with gamma must not leak into the empty closing window
    window(8, 0, 4, -1, p_inc, p_dec);
    chk("coinc_old_inc", p_inc, 1'b0);
    chk("coinc_old_dec", p_dec, 1'b0);

    window(12, 2, 6, 10, p_inc, p_dec);
    chk("coinc_new_inc", p_inc, 1'b1);
    chk("coinc_new_dec", p_dec, 1'b0);

    window(6, 5, -1, -1, p_inc, p_dec);
    chk("first_wins_inc", p_inc, 1'b1);
    chk("first_wins_dec", p_dec, 1'b0);

    learn_en = 1'b0;
    window(6, 3, 3, -1, p_inc, p_dec);
    learn_en = 1'b1;
    chk("learn_off_inc", p_inc, 1'b0);
    chk("learn_off_dec", p_dec, 1'b0);

    // Equal times -> inc; next window exercises counter saturation (30 vs 31)
    window(42, 30, 40, -1, p_inc, p_dec);
    chk("equal_t_inc", p_inc, 1'b1);
    chk("equal_t_dec", p_dec, 1'b0);

    do_cycle(1'b1, 1'b0, 1'b0);
    chk("sat_cnt_inc", inc, 1'b1);
    chk("sat_cnt_dec", dec, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_inc", inc, 1'b0);
    chk("async_rst_dec", dec, 1'b0);
    chk("async_rst_win_valid", win_valid, 1'b0);
    #2;
    rst = 1'b1;

    do_cycle(1'b0, 1'b0, 1'b0);
    window(8, 2, 5, -1, p_inc, p_dec);
    chk("post_rst_first_inc", p_inc, 1'b0);
    chk("post_rst_first_dec", p_dec, 1'b0);
    chk("post_rst_win_valid", win_valid, 1'b1);

    window(4, -1, -1, -1, p_inc, p_dec);
    chk("post_rst_second_inc", p_inc, 1'b1);
    chk("post_rst_second_dec", p_dec, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
